// File: rtl/sum_merge_tree_if.sv
// Frame-in / total-out bundle for the channel sum merge tree.
// The master side drives the frame inputs; the slave side is the tree.
interface sum_merge_tree_if #(
  parameter int NUM_CH = 5,
  parameter int DATA_W = 64,
  parameter int OUT_W  = 64,
  parameter int CNT_W  = 16
);
  logic                     in_valid;
  logic [NUM_CH*DATA_W-1:0] sum_in;
  logic [NUM_CH*DATA_W-1:0] sum_sq_in;
  logic [NUM_CH-1:0]        ch_mask;
  logic                     acc_mode;
  logic                     acc_clear;
  logic                     out_valid;
  logic [OUT_W-1:0]         sum_out;
  logic [OUT_W-1:0]         sum_sq_out;
  logic [CNT_W-1:0]         frame_cnt;
  logic                     overflow;

  modport master (
    output in_valid, sum_in, sum_sq_in, ch_mask, acc_mode, acc_clear,
    input  out_valid, sum_out, sum_sq_out, frame_cnt, overflow
  );

  modport slave (
    input  in_valid, sum_in, sum_sq_in, ch_mask, acc_mode, acc_clear,
    output out_valid, sum_out, sum_sq_out, frame_cnt, overflow
  );
endinterface

// File: rtl/sum_merge_tree.sv
// Pipelined merge of per-channel sums and sums of squares into one total pair,
// with optional cross-frame accumulation, sticky overflow and a frame counter.
module sum_merge_tree #(
  parameter int NUM_CH = 5,
  parameter int DATA_W = 64,
  parameter int OUT_W  = 64,
  parameter int CNT_W  = 16
) (
  input  logic         clk,
  input  logic         reset,
  sum_merge_tree_if.slave bus
);

  localparam int L = (NUM_CH > 1) ? $clog2(NUM_CH) : 0;

  function automatic int node_cnt(input int lvl);
    return (NUM_CH + (1 << lvl) - 1) >> lvl;
  endfunction

  // Clamp keeps unrolled indices in range on branches that are never taken.
  function automatic int idx(input int i);
    return (i < NUM_CH) ? i : NUM_CH - 1;
  endfunction

  logic [OUT_W-1:0] s_lvl [0:L][0:NUM_CH-1];
  logic [OUT_W-1:0] q_lvl [0:L][0:NUM_CH-1];
  logic [OUT_W-1:0] s_nxt [0:L][0:NUM_CH-1];
  logic [OUT_W-1:0] q_nxt [0:L][0:NUM_CH-1];
  logic [L:0]       v_lvl, v_nxt;
  logic [L:0]       m_lvl, m_nxt;
  logic [L:0]       c_lvl, c_nxt;
  logic [OUT_W:0]   ts, tq;

  always_comb begin
    s_nxt = s_lvl;
    q_nxt = q_lvl;
    v_nxt = '0;
    m_nxt = m_lvl;
    c_nxt = c_lvl;
    ts    = '0;
    tq    = '0;
    v_nxt[0] = bus.in_valid;
    if (bus.in_valid) begin
      m_nxt[0] = bus.acc_mode;
      c_nxt[0] = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        s_nxt[0][i] = bus.ch_mask[i] ? OUT_W'(bus.sum_in[i*DATA_W +: DATA_W])    : '0;
        q_nxt[0][i] = bus.ch_mask[i] ? OUT_W'(bus.sum_sq_in[i*DATA_W +: DATA_W]) : '0;
      end
    end
    // Each level carries the frame's running carry flag alongside its data.
    for (int l = 1; l <= L; l++) begin
      v_nxt[l] = v_lvl[l-1];
      if (v_lvl[l-1]) begin
        m_nxt[l] = m_lvl[l-1];
        c_nxt[l] = c_lvl[l-1];
        for (int i = 0; i < NUM_CH; i++) begin
          if (2*i + 1 < node_cnt(l-1)) begin
            ts = {1'b0, s_lvl[l-1][idx(2*i)]} + {1'b0, s_lvl[l-1][idx(2*i+1)]};
            tq = {1'b0, q_lvl[l-1][idx(2*i)]} + {1'b0, q_lvl[l-1][idx(2*i+1)]};
            s_nxt[l][i] = ts[OUT_W-1:0];
            q_nxt[l][i] = tq[OUT_W-1:0];
            c_nxt[l]    = c_nxt[l] | ts[OUT_W] | tq[OUT_W];
          end else if (2*i < node_cnt(l-1)) begin
            s_nxt[l][i] = s_lvl[l-1][idx(2*i)];
            q_nxt[l][i] = q_lvl[l-1][idx(2*i)];
          end else begin
            s_nxt[l][i] = '0;
            q_nxt[l][i] = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_lvl <= '{default: '{default: '0}};
      q_lvl <= '{default: '{default: '0}};
      v_lvl <= '0;
      m_lvl <= '0;
      c_lvl <= '0;
    end else begin
      s_lvl <= s_nxt;
      q_lvl <= q_nxt;
      v_lvl <= v_nxt;
      m_lvl <= m_nxt;
      c_lvl <= c_nxt;
    end
  end

  logic [OUT_W-1:0] acc_s, acc_q, sum_out_r, sum_sq_out_r;
  logic [CNT_W-1:0] frame_cnt_r;
  logic             out_valid_r, overflow_r;
  logic [OUT_W:0]   acc_s_add, acc_q_add;
  logic             tree_v, tree_m, tree_c;

  assign tree_v    = v_lvl[L];
  assign tree_m    = m_lvl[L];
  assign tree_c    = c_lvl[L];
  assign acc_s_add = {1'b0, acc_s} + {1'b0, s_lvl[L][0]};
  assign acc_q_add = {1'b0, acc_q} + {1'b0, q_lvl[L][0]};

  // A coincident clear wipes the running state before the frame lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_s        <= '0;
      acc_q        <= '0;
      sum_out_r    <= '0;
      sum_sq_out_r <= '0;
      frame_cnt_r  <= '0;
      out_valid_r  <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      out_valid_r <= tree_v;
      if (tree_v) begin
        if (tree_m && !bus.acc_clear) begin
          acc_s        <= acc_s_add[OUT_W-1:0];
          acc_q        <= acc_q_add[OUT_W-1:0];
          sum_out_r    <= acc_s_add[OUT_W-1:0];
          sum_sq_out_r <= acc_q_add[OUT_W-1:0];
          frame_cnt_r  <= (frame_cnt_r == '1) ? frame_cnt_r : frame_cnt_r + 1'b1;
          overflow_r   <= overflow_r | tree_c | acc_s_add[OUT_W] | acc_q_add[OUT_W];
        end else begin
          acc_s        <= s_lvl[L][0];
          acc_q        <= q_lvl[L][0];
          sum_out_r    <= s_lvl[L][0];
          sum_sq_out_r <= q_lvl[L][0];
          frame_cnt_r  <= CNT_W'(1);
          overflow_r   <= (overflow_r & ~bus.acc_clear) | tree_c;
        end
      end else if (bus.acc_clear) begin
        acc_s       <= '0;
        acc_q       <= '0;
        frame_cnt_r <= '0;
        overflow_r  <= 1'b0;
      end
    end
  end

  assign bus.out_valid  = out_valid_r;
  assign bus.sum_out    = sum_out_r;
  assign bus.sum_sq_out = sum_sq_out_r;
  assign bus.frame_cnt  = frame_cnt_r;
  assign bus.overflow   = overflow_r;

endmodule

// File: tb/tb_sum_merge_tree.sv
// Directed bench for sum_merge_tree: 5-channel table plus multi-cycle
// accumulate/clear/reset sequences, and 1- and 8-channel latency checks.
module tb_sum_merge_tree;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  sum_merge_tree_if #(.NUM_CH(5), .DATA_W(64), .OUT_W(64), .CNT_W(16)) b5 ();
  sum_merge_tree_if #(.NUM_CH(1), .DATA_W(64), .OUT_W(64), .CNT_W(16)) b1 ();
  sum_merge_tree_if #(.NUM_CH(8), .DATA_W(64), .OUT_W(64), .CNT_W(16)) b8 ();

  sum_merge_tree #(.NUM_CH(5), .DATA_W(64), .OUT_W(64), .CNT_W(16))
    u5 (.clk(clk), .reset(reset), .bus(b5));
  sum_merge_tree #(.NUM_CH(1), .DATA_W(64), .OUT_W(64), .CNT_W(16))
    u1 (.clk(clk), .reset(reset), .bus(b1));
  sum_merge_tree #(.NUM_CH(8), .DATA_W(64), .OUT_W(64), .CNT_W(16))
    u8 (.clk(clk), .reset(reset), .bus(b8));

  typedef struct {
    logic [319:0] s;
    logic [319:0] q;
    logic [4:0]   m;
    logic         md;
    logic [63:0]  es;
    logic [63:0]  eq;
    logic [15:0]  ec;
    logic         eo;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [319:0] pack5(input logic [63:0] a0, a1, a2, a3, a4);
    return {a4, a3, a2, a1, a0};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive5(input logic [319:0] s, input logic [319:0] q,
                        input logic [4:0] m, input logic md);
    @(posedge clk); #1;
    b5.sum_in    = s;
    b5.sum_sq_in = q;
    b5.ch_mask   = m;
    b5.acc_mode  = md;
    b5.in_valid  = 1'b1;
  endtask

  task automatic idle5();
    @(posedge clk); #1;
    b5.in_valid = 1'b0;
  endtask

  // One frame on the 5-channel DUT; optionally pulse acc_clear on its final stage.
  task automatic run5(input string nm, input logic [319:0] s, input logic [319:0] q,
                      input logic [4:0] m, input logic md, input logic clr,
                      input logic [63:0] es, input logic [63:0] eq,
                      input logic [15:0] ec, input logic eo);
    int st;
    bit got;
    drive5(s, q, m, md);
    st = cyc;
    idle5();
    if (clr) begin
      repeat (3) @(posedge clk);
      #1 b5.acc_clear = 1'b1;
      @(posedge clk);
      #1 b5.acc_clear = 1'b0;
    end
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (b5.out_valid) begin
        got = 1;
        check({nm, "_lat"}, 64'(cyc - st), 64'd5);
        check({nm, "_sum"}, b5.sum_out, es);
        check({nm, "_sq"},  b5.sum_sq_out, eq);
        check({nm, "_cnt"}, 64'(b5.frame_cnt), 64'(ec));
        check({nm, "_ovf"}, 64'(b5.overflow), 64'(eo));
      end
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got no out_valid expected out_valid within 20 cycles", nm);
    end else begin
      @(negedge clk);
      check({nm, "_pulse"}, 64'(b5.out_valid), 64'd0);
    end
  endtask

  logic [319:0] d15, q15;
  int st, lat1, lat8, seen;

  initial begin
    d15 = pack5(64'd1, 64'd2, 64'd3, 64'd4, 64'd5);
    q15 = pack5(64'd1, 64'd4, 64'd9, 64'd16, 64'd25);

    tbl[0] = '{d15, q15, 5'b11111, 1'b0, 64'd15, 64'd55, 16'd1, 1'b0};
    tbl[1] = '{d15, q15, 5'b10101, 1'b0, 64'd9,  64'd35, 16'd1, 1'b0};
    tbl[2] = '{d15, q15, 5'b00000, 1'b0, 64'd0,  64'd0,  16'd1, 1'b0};
    tbl[3] = '{d15, q15, 5'b01010, 1'b0, 64'd6,  64'd20, 16'd1, 1'b0};
    tbl[4] = '{d15, q15, 5'b11111, 1'b1, 64'd21, 64'd75, 16'd2, 1'b0};
    tbl[5] = '{d15, q15, 5'b10000, 1'b0, 64'd5,  64'd25, 16'd1, 1'b0};
    tbl[6] = '{pack5('1, 64'd1, 64'd0, 64'd0, 64'd0), pack5(64'd0, 64'd0, 64'd0, 64'd0, 64'd7),
               5'b11111, 1'b0, 64'd0, 64'd7, 16'd1, 1'b1};
    tbl[7] = '{d15, q15, 5'b11111, 1'b0, 64'd15, 64'd55, 16'd1, 1'b1};

    reset = 1'b1;
    b5.in_valid = 0; b5.sum_in = '0; b5.sum_sq_in = '0; b5.ch_mask = '0; b5.acc_mode = 0; b5.acc_clear = 0;
    b1.in_valid = 0; b1.sum_in = '0; b1.sum_sq_in = '0; b1.ch_mask = '0; b1.acc_mode = 0; b1.acc_clear = 0;
    b8.in_valid = 0; b8.sum_in = '0; b8.sum_sq_in = '0; b8.ch_mask = '0; b8.acc_mode = 0; b8.acc_clear = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_valid", 64'(b5.out_valid), 64'd0);
    check("rst_sum",   b5.sum_out, 64'd0);
    check("rst_sq",    b5.sum_sq_out, 64'd0);
    check("rst_cnt",   64'(b5.frame_cnt), 64'd0);
    check("rst_ovf",   64'(b5.overflow), 64'd0);

    for (int i = 0; i < 8; i++)
      run5($sformatf("vec%0d", i), tbl[i].s, tbl[i].q, tbl[i].m, tbl[i].md, 1'b0,
           tbl[i].es, tbl[i].eq, tbl[i].ec, tbl[i].eo);

    // Standalone clear: running state zeroed, visible totals held.
    @(posedge clk); #1 b5.acc_clear = 1'b1;
    @(posedge clk); #1 b5.acc_clear = 1'b0;
    @(negedge clk);
    check("clr_valid", 64'(b5.out_valid), 64'd0);
    check("clr_sum",   b5.sum_out, 64'd15);
    check("clr_sq",    b5.sum_sq_out, 64'd55);
    check("clr_cnt",   64'(b5.frame_cnt), 64'd0);
    check("clr_ovf",   64'(b5.overflow), 64'd0);

    // Three back-to-back accumulating frames.
    drive5(d15, q15, 5'b11111, 1'b1);
    st = cyc;
    drive5(d15, q15, 5'b11111, 1'b1);
    drive5(d15, q15, 5'b11111, 1'b1);
    idle5();
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge clk);
      if (b5.out_valid) seen = cyc - st;
    end
    check("b2b_lat", 64'(seen), 64'd5);
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) @(negedge clk);
      check($sformatf("b2b%0d_valid", k), 64'(b5.out_valid), 64'd1);
      check($sformatf("b2b%0d_sum", k), b5.sum_out, 64'(15 * k));
      check($sformatf("b2b%0d_sq", k),  b5.sum_sq_out, 64'(55 * k));
      check($sformatf("b2b%0d_cnt", k), 64'(b5.frame_cnt), 64'(k));
    end

    run5("clr_coinc", d15, q15, 5'b11111, 1'b1, 1'b1, 64'd15, 64'd55, 16'd1, 1'b0);
    run5("acc_a", pack5(64'hFFFF_FFFF_FFFF_FFF0, 64'd0, 64'd0, 64'd0, 64'd0), '0,
         5'b00001, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd55, 16'd2, 1'b0);
    run5("acc_b", d15, q15, 5'b11111, 1'b1, 1'b0, 64'd14, 64'd110, 16'd3, 1'b1);
    run5("clr_ovf", d15, q15, 5'b11111, 1'b0, 1'b1, 64'd15, 64'd55, 16'd1, 1'b0);

    // Reset with a frame in flight.
    drive5(d15, q15, 5'b11111, 1'b0);
    idle5();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (b5.out_valid) seen++;
    end
    check("rstf_novalid", 64'(seen), 64'd0);
    check("rstf_sum", b5.sum_out, 64'd0);
    check("rstf_sq",  b5.sum_sq_out, 64'd0);
    check("rstf_cnt", 64'(b5.frame_cnt), 64'd0);
    run5("post_rst", d15, q15, 5'b11111, 1'b0, 1'b0, 64'd15, 64'd55, 16'd1, 1'b0);

    // Single-channel and eight-channel instances.
    @(posedge clk); #1;
    b1.sum_in = 64'd7; b1.sum_sq_in = 64'd49; b1.ch_mask = 1'b1; b1.in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      b8.sum_in[k*64 +: 64]    = 64'(k + 1);
      b8.sum_sq_in[k*64 +: 64] = 64'((k + 1) * (k + 1));
    end
    b8.ch_mask = '1; b8.in_valid = 1'b1;
    st = cyc;
    @(posedge clk); #1;
    b1.in_valid = 1'b0; b8.in_valid = 1'b0;
    lat1 = -1; lat8 = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (b1.out_valid && lat1 < 0) begin
        lat1 = cyc - st;
        check("ch1_sum", b1.sum_out, 64'd7);
        check("ch1_sq",  b1.sum_sq_out, 64'd49);
      end
      if (b8.out_valid && lat8 < 0) begin
        lat8 = cyc - st;
        check("ch8_sum", b8.sum_out, 64'd36);
        check("ch8_sq",  b8.sum_sq_out, 64'd204);
        check("ch8_ovf", 64'(b8.overflow), 64'd0);
      end
    end
    check("ch1_lat", 64'(lat1), 64'd2);
    check("ch8_lat", 64'(lat8), 64'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sum_merge_tree.md
Name: sum_merge_tree

Overview:
Parametrised, fully pipelined merge of NUM_CH per-channel partial sums and sum-of-squares into one total pair.
Registered binary adder tree with a valid pipeline, per-channel mask and optional cross-frame accumulation.
Sticky overflow flag and frame counter are included.
Sits after the per-channel statistics engines and feeds the mean/variance stage. Accepts one frame per cycle and has no backpressure.

Parameters:
NUM_CH, 5, number of input channels (>=1)
DATA_W, 64, width of each channel input
OUT_W, 64, width of tree nodes, accumulator and outputs (>= DATA_W)
CNT_W, 16, width of frame counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  qualifies sum_in/sum_sq_in/ch_mask/acc_mode this cycle
sum_in  in  NUM_CH*DATA_W  channel sums, channel k at bits [k*DATA_W +: DATA_W]
sum_sq_in  in  NUM_CH*DATA_W  channel sums of squares, same packing
ch_mask  in  NUM_CH  1 = channel included, 0 = channel forced to zero
acc_mode  in  1  1 = accumulate frame into running total, 0 = pass frame total
acc_clear  in  1  zero accumulator, counter and overflow (acts at final stage)
out_valid  out  1  one-cycle pulse, outputs updated this cycle
sum_out  out  OUT_W  merged (or accumulated) sum
sum_sq_out  out  OUT_W  merged (or accumulated) sum of squares
frame_cnt  out  CNT_W  frames accumulated since last clear, saturating
overflow  out  1  sticky, any addition carried out of OUT_W

Behaviour:
- Reset (async, high): all valid bits, tree registers, accumulators, outputs, frame_cnt and overflow go to 0. In-flight frames are discarded, with no out_valid after reset deasserts for them.
- Stage 0: on in_valid, register each channel zero-extended to OUT_W, ANDed with its ch_mask bit. acc_mode is captured and carried down the pipe with the frame. Stage 0 registers hold when in_valid=0; only the valid bit clears.
- Tree: L = clog2(NUM_CH) registered levels. Each level adds adjacent pairs; an odd trailing node is registered unchanged. The sum and sum_sq trees are identical and independent.
- Final stage, on the tree output valid:
  - mode 0: outputs <= tree result; accumulator <= tree result; frame_cnt <= 1.
  - mode 1: accumulator <= accumulator + tree result; outputs <= new accumulator value; frame_cnt <= frame_cnt + 1, saturating at all-ones.
- Latency: out_valid asserts exactly L+2 cycles after the in_valid edge. This is 5 for NUM_CH=5 and 2 for NUM_CH=1.
- Throughput: one frame per cycle. Back-to-back in_valid gives back-to-back out_valid in order.
- Arithmetic: all adds are modulo 2^OUT_W. Any carry out of any tree node or the accumulator sets overflow, which stays set until reset or acc_clear.
- acc_clear is not pipelined and acts on the final stage in the cycle it is high:
  - Without a coincident tree valid: accumulator, frame_cnt and overflow <= 0. Outputs and out_valid are unchanged (out_valid stays 0).
  - With a coincident tree valid: clear first, then apply the frame. The accumulator and outputs take the tree result, frame_cnt = 1, and overflow = this frame's tree carries only.
- Outputs hold their last value between out_valid pulses.
- All-zero ch_mask produces valid outputs of 0.

Test Plan:
- NUM_CH=5, mask 11111, mode 0, sums 1,2,3,4,5 and squares 1,4,9,16,25 -> out_valid exactly 5 cycles later; sum_out=15, sum_sq_out=55, frame_cnt=1, overflow=0.
- Same data, mask 10101 -> sum_out=9, sum_sq_out=35; mask 00000 -> both 0 with out_valid=1.
- Three back-to-back frames of the first scenario, mode 1, after acc_clear -> three consecutive out_valid pulses with sum 15/30/45, sum_sq 55/110/165, frame_cnt 1/2/3. acc_clear coincident with the 4th frame's final stage -> sum 15, frame_cnt 1.
- OUT_W=64, channel0 = 2^64-1, channel1 = 1, rest 0 -> sum_out=0, overflow=1. Flag persists through the next clean frame and clears on acc_clear.
- Frames in flight, reset pulsed for 1 cycle -> no out_valid for those frames; all outputs read 0. The next frame after reset returns correct values at L+2.
- NUM_CH=1, sums 7 and squares 49 -> out_valid 2 cycles later with 7/49. NUM_CH=8 -> latency 5, sums 1..8 -> 36.
